// File: rtl/calc_pkg.sv
// Shared widths, FSM state encoding and command record for the calculator sequencer.
package calc_pkg;

  localparam int DATA_W = 9;
  localparam int REG_W  = 3;
  localparam int OPC_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    EXEC,
    WAIT,
    WB
  } seq_state_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] src_a;
    logic [REG_W-1:0] src_b;
    logic [REG_W-1:0] dst;
  } calc_cmd_t;

endpackage

// File: rtl/calc_sequencer.sv
// Reg-file read -> ALU execute -> write-back sequencer; done/wr_en at T+4+ALU_LAT (unary one sooner).
// One command in flight: cmd_ready only in IDLE without abort; abort drops the command before WB.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int                    ALU_LAT    = 1,
  parameter logic [(1<<OPC_W)-1:0] UNARY_MASK = '0,
  parameter bit                    WB_ON_OVF  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPC_W-1:0]  cmd_opcode,
  input  logic [REG_W-1:0]  cmd_src_a,
  input  logic [REG_W-1:0]  cmd_src_b,
  input  logic [REG_W-1:0]  cmd_dst,
  input  logic              abort,
  output logic [REG_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] reg_val,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic              alu_assign_op1,
  output logic              alu_assign_op2,
  output logic              alu_en,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_oflag,
  output logic              wr_en,
  output logic [REG_W-1:0]  wr_sel,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              ovf_err
);

  seq_state_t        state, state_nxt;
  calc_cmd_t         cmd_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              ovf_q;
  logic              accept;
  logic              wait_done;

  assign accept    = (state == IDLE) && cmd_valid && !abort;
  assign wait_done = (state == WAIT) && (cnt_q == 4'd0) && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_q <= '{opcode: cmd_opcode, src_a: cmd_src_a, src_b: cmd_src_b, dst: cmd_dst};
        ovf_q <= 1'b0;
      end
      if (state == EXEC)
        cnt_q <= 4'(ALU_LAT - 1);
      else if (state == WAIT && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
      // Result and flag are captured together so WB sees a consistent pair.
      if (wait_done) begin
        wr_data_q <= alu_result;
        ovf_q     <= alu_oflag;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    cmd_ready      = 1'b0;
    busy           = 1'b1;
    reg_sel        = '0;
    alu_opcode     = cmd_q.opcode;
    alu_assign_op1 = 1'b0;
    alu_assign_op2 = 1'b0;
    alu_en         = 1'b0;
    wr_en          = 1'b0;
    wr_sel         = '0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        alu_opcode = '0;
        cmd_ready  = !abort;
        if (accept) state_nxt = RD_A;
      end
      RD_A: begin
        reg_sel        = cmd_q.src_a;
        alu_assign_op1 = 1'b1;
        state_nxt      = UNARY_MASK[cmd_q.opcode] ? EXEC : RD_B;
      end
      RD_B: begin
        reg_sel        = cmd_q.src_b;
        alu_assign_op2 = 1'b1;
        state_nxt      = EXEC;
      end
      EXEC: begin
        alu_en    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_nxt = WB;
      end
      WB: begin
        done      = 1'b1;
        wr_en     = !ovf_q || WB_ON_OVF;
        wr_sel    = cmd_q.dst;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // WB completes in its own cycle, so abort there is too late to matter.
    if (abort && state != IDLE && state != WB) state_nxt = IDLE;
  end

  assign wr_data = wr_data_q;
  assign ovf_err = ovf_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: timing, unary skip, overflow, abort, reset and ALU_LAT=3 throughput.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic              rst;
  logic              cmd_valid, cmd_ready, abort;
  logic [OPC_W-1:0]  cmd_opcode, alu_opcode;
  logic [REG_W-1:0]  cmd_src_a, cmd_src_b, cmd_dst, reg_sel, wr_sel;
  logic [DATA_W-1:0] reg_val, alu_result, wr_data;
  logic              alu_oflag, op1, op2, alu_en, wr_en, busy, done, ovf_err;

  logic              c3_valid, c3_ready, abort3;
  logic [OPC_W-1:0]  c3_opcode, alu_opcode3;
  logic [REG_W-1:0]  c3_src_a, c3_src_b, c3_dst, reg_sel3, wr_sel3;
  logic [DATA_W-1:0] reg_val3, wr_data3;
  logic              op1_3, op2_3, alu_en3, wr_en3, busy3, done3, ovf_err3;

  logic [DATA_W-1:0] rf [8];
  assign reg_val  = rf[reg_sel];
  assign reg_val3 = rf[reg_sel3];

  calc_sequencer #(.ALU_LAT(1), .UNARY_MASK(8'h80), .WB_ON_OVF(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .abort(abort),
    .reg_sel(reg_sel), .reg_val(reg_val), .alu_opcode(alu_opcode),
    .alu_assign_op1(op1), .alu_assign_op2(op2), .alu_en(alu_en),
    .alu_result(alu_result), .alu_oflag(alu_oflag),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .busy(busy), .done(done), .ovf_err(ovf_err)
  );

  calc_sequencer #(.ALU_LAT(3), .UNARY_MASK(8'h80), .WB_ON_OVF(1'b1)) u_dut3 (
    .clk(clk), .rst(rst),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_opcode(c3_opcode),
    .cmd_src_a(c3_src_a), .cmd_src_b(c3_src_b), .cmd_dst(c3_dst), .abort(abort3),
    .reg_sel(reg_sel3), .reg_val(reg_val3), .alu_opcode(alu_opcode3),
    .alu_assign_op1(op1_3), .alu_assign_op2(op2_3), .alu_en(alu_en3),
    .alu_result(alu_result), .alu_oflag(alu_oflag),
    .wr_en(wr_en3), .wr_sel(wr_sel3), .wr_data(wr_data3),
    .busy(busy3), .done(done3), .ovf_err(ovf_err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] opc, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d);
    cmd_valid  = 1'b1;
    cmd_opcode = opc;
    cmd_src_a  = a;
    cmd_src_b  = b;
    cmd_dst    = d;
  endtask

  int acc [4];
  int dn  [4];
  int nacc, ndn;

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 9'(i * 17);
    rst = 1'b1; abort = 1'b0; cmd_valid = 1'b0;
    cmd_opcode = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
    alu_result = '0; alu_oflag = 1'b0;
    c3_valid = 1'b0; c3_opcode = '0; c3_src_a = '0; c3_src_b = '0; c3_dst = '0; abort3 = 1'b0;

    // Reset state
    step(); #1;
    chk("rst_ready", cmd_ready, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_ovf", ovf_err, 0); chk("rst_regsel", reg_sel, 0); chk("rst_opc", alu_opcode, 0);
    chk("rst_wrsel", wr_sel, 0); chk("rst_wrdata", wr_data, 0); chk("rst_wren", wr_en, 0);
    step(); rst = 1'b0; #1;
    chk("idle_busy", busy, 0);

    // Binary command r1,r2 -> r3
    issue(3'd0, 3'd1, 3'd2, 3'd3); alu_result = 9'h00A; #1;
    chk("a_ready", cmd_ready, 1);
    step(); cmd_valid = 1'b0; #1;
    chk("a_t1_sel", reg_sel, 1); chk("a_t1_op1", op1, 1); chk("a_t1_op2", op2, 0);
    chk("a_t1_busy", busy, 1); chk("a_t1_ready", cmd_ready, 0);
    step(); #1;
    chk("a_t2_sel", reg_sel, 2); chk("a_t2_op2", op2, 1); chk("a_t2_op1", op1, 0);
    step(); #1;
    chk("a_t3_en", alu_en, 1); chk("a_t3_sel", reg_sel, 0);
    step(); #1;
    chk("a_t4_en", alu_en, 0); chk("a_t4_done", done, 0); chk("a_t4_wren", wr_en, 0);
    step(); #1;
    chk("a_t5_done", done, 1); chk("a_t5_wren", wr_en, 1); chk("a_t5_wrsel", wr_sel, 3);
    chk("a_t5_wrdata", wr_data, 9'h00A);
    step(); #1;
    chk("a_t6_done", done, 0); chk("a_t6_wren", wr_en, 0); chk("a_t6_busy", busy, 0);
    chk("a_t6_wrdata", wr_data, 9'h00A);

    // Unary opcode 7 on r4 -> r4
    issue(3'd7, 3'd4, 3'd5, 3'd4); alu_result = 9'h155; #1;
    step(); cmd_valid = 1'b0; #1;
    chk("u_t1_sel", reg_sel, 4); chk("u_t1_op1", op1, 1); chk("u_t1_opc", alu_opcode, 7);
    step(); #1;
    chk("u_t2_en", alu_en, 1); chk("u_t2_op2", op2, 0);
    step(); #1;
    chk("u_t3_done", done, 0);
    step(); #1;
    chk("u_t4_done", done, 1); chk("u_t4_wren", wr_en, 1); chk("u_t4_wrsel", wr_sel, 4);
    chk("u_t4_wrdata", wr_data, 9'h155);
    step(); #1;
    chk("u_t5_busy", busy, 0); chk("u_t5_opc", alu_opcode, 0);

    // Overflow suppresses write-back
    issue(3'd1, 3'd5, 3'd6, 3'd7); alu_result = 9'h0FF; alu_oflag = 1'b1; #1;
    step(); cmd_valid = 1'b0; #1;
    step(); step(); step(); step(); #1;
    chk("o_done", done, 1); chk("o_wren", wr_en, 0); chk("o_ovf", ovf_err, 1);
    chk("o_wrdata", wr_data, 9'h0FF);
    step(); #1;
    chk("o_idle_ovf", ovf_err, 1); chk("o_idle_busy", busy, 0);
    step(); #1;
    chk("o_hold_ovf", ovf_err, 1);

    // Abort in IDLE blocks acceptance
    abort = 1'b1; alu_oflag = 1'b0; alu_result = 9'h033;
    issue(3'd2, 3'd1, 3'd2, 3'd3); #1;
    chk("ai_ready", cmd_ready, 0);
    step(); abort = 1'b0; #1;
    chk("ai_busy", busy, 0); chk("ai_ready2", cmd_ready, 1);
    step(); cmd_valid = 1'b0; #1;
    chk("ab_ovf_clr", ovf_err, 0); chk("ab_busy", busy, 1);

    // Abort in EXEC, then back-to-back command
    step(); step(); #1;
    chk("ab_exec_en", alu_en, 1);
    abort = 1'b1; issue(3'd3, 3'd6, 3'd0, 3'd2); #1;
    chk("ab_exec_ready", cmd_ready, 0);
    step(); abort = 1'b0; #1;
    chk("ab_idle_busy", busy, 0); chk("ab_idle_en", alu_en, 0); chk("ab_idle_wren", wr_en, 0);
    chk("ab_idle_done", done, 0); chk("ab_idle_ready", cmd_ready, 1);
    step(); cmd_valid = 1'b0; alu_result = 9'h1C4; #1;
    chk("b2b_busy", busy, 1); chk("b2b_sel", reg_sel, 6); chk("b2b_opc", alu_opcode, 3);
    step(); step(); step(); step(); #1;
    chk("b2b_done", done, 1); chk("b2b_wren", wr_en, 1); chk("b2b_wrsel", wr_sel, 2);
    chk("b2b_wrdata", wr_data, 9'h1C4);

    // Reset while in WAIT
    step(); #1;
    issue(3'd0, 3'd1, 3'd2, 3'd3); alu_result = 9'h0AA; #1;
    step(); cmd_valid = 1'b0; step(); step(); step(); #1;
    chk("rw_busy", busy, 1); chk("rw_en", alu_en, 0);
    rst = 1'b1; #1;
    chk("rw_rst_busy", busy, 0); chk("rw_rst_ready", cmd_ready, 1); chk("rw_rst_wren", wr_en, 0);
    chk("rw_rst_done", done, 0); chk("rw_rst_wrdata", wr_data, 0); chk("rw_rst_opc", alu_opcode, 0);
    step(); #1;
    chk("rw_hold_wren", wr_en, 0); chk("rw_hold_done", done, 0);
    rst = 1'b0;
    step(); #1;
    chk("rw_after_busy", busy, 0);

    // ALU_LAT=3 with cmd_valid held high
    c3_valid = 1'b1; c3_opcode = 3'd0; c3_src_a = 3'd1; c3_src_b = 3'd2; c3_dst = 3'd5;
    alu_result = 9'h0AB; #1;
    nacc = 0; ndn = 0;
    for (int i = 0; i < 24; i++) begin
      if (c3_ready) begin
        if (nacc < 4) acc[nacc] = cyc + 1;
        nacc++;
      end
      if (done3) begin
        if (ndn < 4) dn[ndn] = cyc + 1;
        ndn++;
        chk("l3_wren", wr_en3, 1);
        chk("l3_wrdata", wr_data3, 9'h0AB);
      end
      step(); #1;
    end
    c3_valid = 1'b0;
    chk("l3_nacc", nacc, 3); chk("l3_ndone", ndn, 3);
    chk("l3_gap1", acc[1] - acc[0], 8); chk("l3_gap2", acc[2] - acc[1], 8);
    chk("l3_lat0", dn[0] - acc[0], 7); chk("l3_lat1", dn[1] - acc[1], 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
